// File: rtl/output_buf_pkg.sv
// Shared types and saturating helpers for the output accumulation group.
// Saturation helpers are only referenced when OUT_SAT_EN is defined.
package output_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } og_state_e;

    // Operands arrive sign-extended to this width so any ACC_W below it cannot overflow the helper.
    localparam int SAT_MAX_W = 64;

    function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
        input logic signed [SAT_MAX_W-1:0] v,
        input int                          acc_w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) <<< (acc_w - 1)) - SAT_MAX_W'(1);
        lo = -hi - SAT_MAX_W'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          acc_w
    );
        return sat_clamp(a + b, acc_w);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_sub(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          acc_w
    );
        return sat_clamp(a - b, acc_w);
    endfunction

endpackage

// File: rtl/accum_entry_bank.sv
// DEPTH x ACC_W result buffer with overwrite/accumulate write port, read port and clear port.
// OUT_SAT_EN makes the accumulate path saturate instead of wrapping.
module accum_entry_bank
    import output_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = 32,
    parameter int IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en,
    input  logic             wr_accum,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ACC_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ACC_W-1:0] rd_data,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic [ACC_W-1:0] entry_q [DEPTH];
    logic [ACC_W-1:0] wr_value;

    always_comb begin
        wr_value = wr_data;
        if (wr_accum) begin
`ifdef OUT_SAT_EN
            wr_value = ACC_W'(sat_add(SAT_MAX_W'($signed(entry_q[wr_idx])),
                                      SAT_MAX_W'($signed(wr_data)), ACC_W));
`else
            wr_value = entry_q[wr_idx] + wr_data;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                entry_q[wr_idx] <= wr_value;
            end
            if (clr_en) begin
                entry_q[clr_idx] <= '0;
            end
        end
    end

    assign rd_data = entry_q[rd_idx];

endmodule

// File: rtl/output_accum_group.sv
// Bit-serial PIM output assembly: shift-add per lane, lane reduction, buffered accumulate and zero-point drain.
// Define OUT_SAT_EN for saturating accumulate/drain arithmetic and the out_sat_o flag.
module output_accum_group
    import output_buf_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IN_W        = 8,
    parameter int SHIFT_STEPS = 4,
    parameter int DEPTH       = 4,
    parameter int ACC_W       = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic                       accum_i,
    input  logic [$clog2(DEPTH)-1:0]   idx_i,
    input  logic                       in_valid_i,
    input  logic [NUM_CH*IN_W-1:0]     in_data_i,
    input  logic                       zp_we_i,
    input  logic [ACC_W-1:0]           zp_i,
    input  logic                       drain_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ACC_W-1:0]           out_data_o,
    output logic                       busy_o,
`ifdef OUT_SAT_EN
    output logic                       done_o,
    output logic                       out_sat_o
`else
    output logic                       done_o
`endif
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int STEP_W    = $clog2(SHIFT_STEPS);
    localparam int MIN_ACC_W = IN_W + SHIFT_STEPS + $clog2(NUM_CH) + 1;

    generate
        if (ACC_W < MIN_ACC_W) begin : g_acc_w_too_small
            $error("output_accum_group: ACC_W must be at least IN_W+SHIFT_STEPS+clog2(NUM_CH)+1");
        end
        if (ACC_W >= SAT_MAX_W) begin : g_acc_w_too_large
            $error("output_accum_group: ACC_W must be below SAT_MAX_W");
        end
        if (DEPTH < 2 || SHIFT_STEPS < 2) begin : g_size_too_small
            $error("output_accum_group: DEPTH and SHIFT_STEPS must be at least 2");
        end
    endgenerate

    og_state_e         state_q;
    logic [STEP_W-1:0] step_q;
    logic              mode_q;
    logic              accum_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  rd_ptr_q;
    logic [ACC_W-1:0]  zp_q;
    logic [ACC_W-1:0]  lane_acc_q [NUM_CH];
    logic [ACC_W-1:0]  lane_sum;
    logic [ACC_W-1:0]  rd_data;
    logic              last_step;

    assign last_step = (step_q == STEP_W'(SHIFT_STEPS - 1));

    always_comb begin
        lane_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lane_sum = lane_sum + lane_acc_q[c];
        end
    end

    // zp_r is frozen during DRAIN so a stalled beat never changes under the consumer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            step_q   <= '0;
            mode_q   <= 1'b0;
            accum_q  <= 1'b0;
            idx_q    <= '0;
            rd_ptr_q <= '0;
            zp_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                lane_acc_q[c] <= '0;
            end
        end else begin
            if (zp_we_i && state_q != DRAIN) begin
                zp_q <= zp_i;
            end
            case (state_q)
                IDLE: begin
                    if (drain_i) begin
                        state_q  <= DRAIN;
                        rd_ptr_q <= '0;
                    end else if (start_i) begin
                        mode_q  <= mode_i;
                        accum_q <= accum_i;
                        idx_q   <= idx_i;
                        step_q  <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            lane_acc_q[c] <= '0;
                        end
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (in_valid_i) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (mode_q && last_step) begin
                                lane_acc_q[c] <= lane_acc_q[c] - (ACC_W'(in_data_i[c*IN_W +: IN_W]) << step_q);
                            end else begin
                                lane_acc_q[c] <= lane_acc_q[c] + (ACC_W'(in_data_i[c*IN_W +: IN_W]) << step_q);
                            end
                        end
                        step_q <= step_q + STEP_W'(1);
                        if (last_step) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (rd_ptr_q == IDX_W'(DEPTH - 1)) begin
                            state_q  <= IDLE;
                            rd_ptr_q <= '0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    accum_entry_bank #(
        .DEPTH (DEPTH),
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_en    (state_q == COMMIT),
        .wr_accum (accum_q),
        .wr_idx   (idx_q),
        .wr_data  (lane_sum),
        .rd_idx   (rd_ptr_q),
        .rd_data  (rd_data),
        .clr_en   (state_q == DRAIN && out_ready_i),
        .clr_idx  (rd_ptr_q)
    );

    assign out_valid_o = (state_q == DRAIN);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == COMMIT);

`ifdef OUT_SAT_EN
    logic signed [SAT_MAX_W-1:0] diff_full;
    logic signed [SAT_MAX_W-1:0] diff_sat;

    // Clipping is detected by comparing the clamped difference with the exact wide one.
    assign diff_full  = SAT_MAX_W'($signed(rd_data)) - SAT_MAX_W'($signed(zp_q));
    assign diff_sat   = sat_sub(SAT_MAX_W'($signed(rd_data)), SAT_MAX_W'($signed(zp_q)), ACC_W);
    assign out_data_o = diff_sat[ACC_W-1:0];
    assign out_sat_o  = (diff_full != diff_sat);
`else
    assign out_data_o = rd_data - zp_q;
`endif

endmodule

// File: tb/tb_output_accum_group.sv
// Scoreboard bench for output_accum_group: directed result sequences, drains, stalls and reset abort.
// Expected drain beats are queued by the stimulus and checked by a separate monitor process.
module tb_output_accum_group;

    typedef struct {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        accum_i = 1'b0;
    logic [1:0]  idx_i = '0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic        zp_we_i = 1'b0;
    logic [31:0] zp_i = '0;
    logic        drain_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        busy_o;
    logic        done_o;
`ifdef OUT_SAT_EN
    logic        out_sat_o;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    output_accum_group #(
        .NUM_CH      (4),
        .IN_W        (8),
        .SHIFT_STEPS (4),
        .DEPTH       (4),
        .ACC_W       (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .accum_i     (accum_i),
        .idx_i       (idx_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .zp_we_i     (zp_we_i),
        .zp_i        (zp_i),
        .drain_i     (drain_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
`ifdef OUT_SAT_EN
        .done_o      (done_o),
        .out_sat_o   (out_sat_o)
`else
        .done_o      (done_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [31:0] data, input logic sat);
        exp_t e;
        e.data = data;
        e.sat  = sat;
        exp_q.push_back(e);
    endtask

    // One full result sequence; gaps insert idle cycles between beats, poke pulses start/drain inside them.
    task automatic applyStimulus(input logic [1:0] idx, input logic mode, input logic accum,
                                 input logic [31:0] data, input int gap, input logic poke);
        start_i = 1'b1;
        mode_i  = mode;
        accum_i = accum;
        idx_i   = idx;
        tick();
        start_i = 1'b0;
        mode_i  = ~mode;
        accum_i = ~accum;
        idx_i   = idx + 2'd1;
        for (int b = 0; b < 4; b++) begin
            in_valid_i = 1'b1;
            in_data_i  = data;
            tick();
            in_valid_i = 1'b0;
            in_data_i  = '0;
            if (b < 3) begin
                for (int g = 0; g < gap; g++) begin
                    start_i = poke;
                    drain_i = poke;
                    tick();
                    start_i = 1'b0;
                    drain_i = 1'b0;
                end
            end
        end
        tick();
    endtask

    task automatic setZp(input logic [31:0] v);
        zp_we_i = 1'b1;
        zp_i    = v;
        tick();
        zp_we_i = 1'b0;
    endtask

    task automatic runDrain();
        int n;
        drain_i = 1'b1;
        tick();
        drain_i     = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        out_ready_i = 1'b0;
        checkOutput("drain_timeout", {31'b0, busy_o}, 32'd0);
        checkOutput("drain_beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk_i);
                    if (done_o === 1'b1) begin
                        done_cnt++;
                    end
                    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_beat: got 0x%08h, expected no beat", out_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("drain_beat", out_data_o, e.data);
`ifdef OUT_SAT_EN
                            checkOutput("drain_sat", {31'b0, out_sat_o}, {31'b0, e.sat});
`endif
                        end
                    end
                end
            end
        join_none

        tick();
        tick();
        rst_ni = 1'b1;
        checkOutput("reset_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("reset_done", {31'b0, done_o}, 32'd0);
        checkOutput("reset_data", out_data_o, 32'd0);

        $display("[TB] test 1: unsigned overwrite");
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h01010101, 0, 1'b0);
        pushExp(32'h0000003C, 1'b0);
        for (int i = 0; i < 3; i++) pushExp(32'h0, 1'b0);
        runDrain();

        $display("[TB] test 2: signed bit planes");
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h01010101, 0, 1'b0);
        pushExp(32'hFFFFFFFC, 1'b0);
        for (int i = 0; i < 3; i++) pushExp(32'h0, 1'b0);
        runDrain();

        $display("[TB] test 3: accumulate and zero point");
        applyStimulus(2'd1, 1'b0, 1'b0, 32'h01010101, 0, 1'b0);
        applyStimulus(2'd1, 1'b0, 1'b1, 32'h01010101, 0, 1'b0);
        setZp(32'd20);
        pushExp(32'hFFFFFFEC, 1'b0);
        pushExp(32'd100, 1'b0);
        pushExp(32'hFFFFFFEC, 1'b0);
        pushExp(32'hFFFFFFEC, 1'b0);
        runDrain();
        setZp(32'd0);
        for (int i = 0; i < 4; i++) pushExp(32'h0, 1'b0);
        runDrain();

        $display("[TB] test 4: input gaps with start pulses");
        d0 = done_cnt;
        applyStimulus(2'd2, 1'b0, 1'b0, 32'h01010101, 2, 1'b1);
        checkOutput("done_pulse_count", 32'(done_cnt - d0), 32'd1);
        checkOutput("idle_after_commit", {31'b0, busy_o}, 32'd0);
        pushExp(32'h0, 1'b0);
        pushExp(32'h0, 1'b0);
        pushExp(32'd60, 1'b0);
        pushExp(32'h0, 1'b0);
        runDrain();

        $display("[TB] test 5: backpressure, zp write in drain, reset abort");
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h01010101, 0, 1'b0);
        applyStimulus(2'd1, 1'b1, 1'b0, 32'h01010101, 0, 1'b0);
        applyStimulus(2'd2, 1'b0, 1'b0, 32'h01010101, 0, 1'b0);
        setZp(32'd5);
        pushExp(32'd55, 1'b0);
        pushExp(32'hFFFFFFF7, 1'b0);
        drain_i = 1'b1;
        tick();
        drain_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checkOutput("stall_valid", {31'b0, out_valid_o}, 32'd1);
            checkOutput("stall_data", out_data_o, 32'd55);
            zp_we_i = (s == 0);
            zp_i    = 32'd1000;
            tick();
            zp_we_i = 1'b0;
        end
        checkOutput("stall_data_after_zp", out_data_o, 32'd55);
        out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        checkOutput("beat2_valid", {31'b0, out_valid_o}, 32'd1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        checkOutput("abort_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("abort_data", out_data_o, 32'd0);
        checkOutput("abort_beats_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) pushExp(32'h0, 1'b0);
        runDrain();

        $display("[TB] test 6: zero-point subtraction overflow");
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h01010101, 0, 1'b0);
        setZp(32'h7FFFFFFF);
`ifdef OUT_SAT_EN
        pushExp(32'h80000000, 1'b1);
`else
        pushExp(32'h7FFFFFFD, 1'b0);
`endif
        for (int i = 0; i < 3; i++) pushExp(32'h80000001, 1'b0);
        runDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
